fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage of the 16-bit RISC datapath. It sits directly upstream of the instruction memory and feeds decode:
- Holds the program counter and drives the word-aligned byte address into the combinational-read instruction memory.
- Captures the returned 16-bit instruction into an IF/ID pipeline register presented to decode over a valid/ready handshake.
- Accepts redirects (taken branch/jump, resolved using the ALU zero flag) from execute, flushing the held instruction.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- imem_pc  out  16  byte address to instruction memory; equals the PC register (combinational).
- imem_instr  in  16  instruction word returned combinationally for imem_pc.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_ready  in  1  decode accepts the IF/ID contents this cycle.
- id_instr  out  16  held instruction.
- id_pc  out  16  address the held instruction was fetched from.
- id_pc_plus2  out  16  id_pc + 2, modulo 2^16.
- redirect  in  1  execute requests a PC change this cycle.
- redirect_pc  in  16  redirect target; bit 0 forced to 0 when loaded.
- halt  in  1  suppress new fetches while high.
- misalign  out  1  sticky; set when redirect is taken with redirect_pc[0]=1.
- fetch_cnt  out  16  count of completed decode handshakes, wraps at 16'hFFFF -> 0.

## Operation
- Reset values:
  - PC=RESET_PC, so imem_pc=RESET_PC.
  - id_valid=0, id_instr=0, id_pc=0, id_pc_plus2=16'h0002, misalign=0, fetch_cnt=0.
- Definitions:
  - load_ok = !id_valid || id_ready (IF/ID slot free or being drained).
  - handshake = id_valid && id_ready.
- Per-cycle priority:
  1. **redirect=1:**
     - PC <= {redirect_pc[15:1],1'b0}.
     - id_valid <= 0, which flushes any held instruction, including one stalled with id_ready=0.
     - No capture this cycle.
     - misalign <= misalign | redirect_pc[0].
  2. **halt=1 (no redirect):**
     - PC holds; no capture.
     - If handshake, id_valid <= 0; otherwise the IF/ID register holds.
  3. **load_ok (no redirect, no halt), i.e. fetch:**
     - id_instr <= imem_instr, id_pc <= PC, id_pc_plus2 <= PC+2.
     - id_valid <= 1, PC <= PC+2.
  4. **Otherwise (stall, id_valid=1, id_ready=0):** PC, id_valid, id_instr, id_pc, id_pc_plus2 all hold.
- fetch_cnt increments on every handshake, including a handshake coinciding with redirect. A flushed instruction that did not handshake is not counted.
- PC arithmetic is 16-bit unsigned and wraps: 16'hFFFE + 2 = 16'h0000. id_pc_plus2 wraps identically.
- PC bit 0 is always 0. The instruction memory indexes words by PC[15:1].
- Asserting rst_n low at any point, including mid-stall or during a redirect, immediately forces all reset values regardless of clk.

## Timing
- Fetch latency: 1 cycle. The instruction at address P appears on id_instr, with id_valid=1, in the cycle after PC=P.
- Throughput: 1 instruction/cycle while id_ready=1, halt=0, redirect=0.
- Redirect penalty: 1 bubble.
  - Cycle of redirect: id_valid drops at the next edge.
  - Cycle after: PC=target, id_valid=0.
  - Cycle after that: id_valid=1, id_pc=target.
- id_valid/id_instr/id_pc never change while id_valid=1 and id_ready=0, except on redirect or reset.
- All outputs except imem_pc are registered. imem_pc is a direct copy of the PC register; there is no combinational path from any input to any output.
- Reset release: the first fetch occurs on the first rising edge with rst_n=1; id_valid=1 after that edge.

## Test plan
- **Streaming:** reset with RESET_PC=0, memory words 0x1111, 0x2222, 0x3333 at byte addresses 0, 2, 4; id_ready=1.
  - Required: consecutive cycles show id_instr 0x1111/0x2222/0x3333 with id_pc 0/2/4 and id_pc_plus2 2/4/6.
  - Required: fetch_cnt=3 after the third handshake.
- **Stall:** drop id_ready for 3 cycles while id_pc=2.
  - Required: id_instr=0x2222, id_pc=2, imem_pc=4 constant for all 3 cycles.
  - Required: on id_ready=1 the next id_pc=4, with no duplicate or skipped instruction.
- **Redirect during stall:** id_valid=1, id_ready=0, redirect=1, redirect_pc=0x0040.
  - Required: next cycle id_valid=0, imem_pc=0x0040, fetch_cnt unchanged.
  - Required: the following cycle id_pc=0x0040.
- **Wrap and misalign:**
  - Redirect to 0xFFFE, id_ready=1. Required: id_pc sequence 0xFFFE then 0x0000, and id_pc_plus2 for 0xFFFE is 0x0000.
  - Redirect with redirect_pc=0x0011. Required: imem_pc=0x0010, misalign=1, and misalign stays 1 until reset.
- **Halt:** halt=1 with id_valid=1, id_ready=1.
  - Required: id_valid=0 next cycle and PC frozen for the whole halt.
  - Required: on deassert, fetch resumes at the frozen PC.
- **Async reset mid-operation:** pulse rst_n low between clock edges during streaming with PC=0x0008.
  - Required: outputs immediately show reset values (imem_pc=RESET_PC, id_valid=0, fetch_cnt=0, misalign=0).
  - Required: fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, redirect/halt handling
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_pc,
  input  logic [15:0] imem_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_plus2,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        misalign,
  output logic [15:0] fetch_cnt
);

  localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

  logic [15:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] id_instr_q, id_instr_d;
  logic [15:0] id_pc_q, id_pc_d;
  logic [15:0] id_pc_plus2_q, id_pc_plus2_d;
  logic        misalign_q, misalign_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  logic load_ok;
  logic handshake;

  assign load_ok   = !id_valid_q || id_ready;
  assign handshake = id_valid_q && id_ready;

  // Next-state: redirect beats halt beats fetch; otherwise the IF/ID slot is stalled and holds
  always_comb begin
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus2_d = id_pc_plus2_q;
    misalign_d    = misalign_q;
    fetch_cnt_d   = handshake ? fetch_cnt_q + 16'd1 : fetch_cnt_q;

    if (redirect) begin
      pc_d       = {redirect_pc[15:1], 1'b0};
      id_valid_d = 1'b0;
      misalign_d = misalign_q | redirect_pc[0];
    end else if (halt) begin
      if (handshake) begin
        id_valid_d = 1'b0;
      end
    end else if (load_ok) begin
      id_instr_d    = imem_instr;
      id_pc_d       = pc_q;
      id_pc_plus2_d = pc_q + 16'd2;
      id_valid_d    = 1'b1;
      pc_d          = pc_q + 16'd2;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC_ALIGNED;
      id_valid_q    <= 1'b0;
      id_instr_q    <= 16'h0000;
      id_pc_q       <= 16'h0000;
      id_pc_plus2_q <= 16'h0002;
      misalign_q    <= 1'b0;
      fetch_cnt_q   <= 16'h0000;
    end else begin
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus2_q <= id_pc_plus2_d;
      misalign_q    <= misalign_d;
      fetch_cnt_q   <= fetch_cnt_d;
    end
  end

  assign imem_pc     = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus2 = id_pc_plus2_q;
  assign misalign    = misalign_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule
